// File: rtl/pipe_frame_arbiter_if.sv
// Bundle of the requester-side and pipeline-side signals of the frame arbiter.
// The master modport is the environment (requesters plus downstream pipeline).
// The slave modport is the arbiter itself.
interface pipe_frame_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int SRC_W  = $clog2(N_REQ)
);
   logic [N_REQ*DATA_W-1:0] req_data_i;
   logic [N_REQ-1:0]        req_valid_i;
   logic [N_REQ-1:0]        req_last_i;
   logic [N_REQ-1:0]        req_ready_o;
   logic [DATA_W-1:0]       data_o;
   logic                    valid_o;
   logic                    last_o;
   logic                    err_o;
   logic [SRC_W-1:0]        src_o;
   logic                    ready_i;
   logic                    busy_o;

   modport master (
      output req_data_i, req_valid_i, req_last_i, ready_i,
      input  req_ready_o, data_o, valid_o, last_o, err_o, src_o, busy_o
   );

   modport slave (
      input  req_data_i, req_valid_i, req_last_i, ready_i,
      output req_ready_o, data_o, valid_o, last_o, err_o, src_o, busy_o
   );
endinterface

// File: rtl/pipe_frame_arbiter.sv
// Round-robin, frame-locked arbiter sharing one registered output stage
// between N_REQ byte-stream requesters. A requester keeps the grant for a
// whole frame. Frames longer than MAX_BEATS are cut short with last+err, and
// the remaining input beats are drained without being forwarded.
module pipe_frame_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BEATS = 1522
) (
   input logic                clk,
   input logic                rst_n,
   pipe_frame_arbiter_if.slave bus
);
   localparam int SRC_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

   typedef enum logic [1:0] {IDLE, FWD, DRAIN} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [SRC_W-1:0]   grant;
   logic [SRC_W-1:0]   rr_ptr;
   logic [SRC_W-1:0]   pick;
   logic [SRC_W-1:0]   idx;
   logic               any_valid;
   logic [CNT_W-1:0]   beat_cnt;
   logic [N_REQ-1:0]   ready_vec;
   logic               g_valid;
   logic               g_last;
   logic [DATA_W-1:0]  g_data;
   logic               load;
   logic               trunc;

   logic [DATA_W-1:0]  data_q;
   logic               valid_q;
   logic               last_q;
   logic               err_q;
   logic [SRC_W-1:0]   src_q;

   assign g_valid = bus.req_valid_i[grant];
   assign g_last  = bus.req_last_i[grant];
   assign g_data  = bus.req_data_i[int'(grant)*DATA_W +: DATA_W];

   // Round-robin pick: the first valid requester after rr_ptr wins, so the
   // loop runs from the farthest offset down and the nearest one overwrites.
   always_comb begin
      pick      = '0;
      idx       = '0;
      any_valid = 1'b0;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = SRC_W'((int'(rr_ptr) + i) % N_REQ);
         if (bus.req_valid_i[idx]) begin
            pick      = idx;
            any_valid = 1'b1;
         end
      end
   end

   // Next state, per-requester ready, and the load/truncate strobes.
   always_comb begin
      state_nxt = state;
      ready_vec = '0;
      load      = 1'b0;
      trunc     = 1'b0;
      case (state)
         IDLE: begin
            if (any_valid) state_nxt = FWD;
         end
         FWD: begin
            ready_vec[grant] = !valid_q || bus.ready_i;
            if (g_valid && ready_vec[grant]) begin
               load = 1'b1;
               if (g_last) begin
                  state_nxt = IDLE;
               end else if (beat_cnt == CNT_LAST) begin
                  trunc     = 1'b1;
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            ready_vec[grant] = 1'b1;
            if (g_valid && g_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control registers: state, grant capture at arbitration, frame beat count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant    <= '0;
         rr_ptr   <= SRC_W'(N_REQ - 1);
         beat_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && any_valid) begin
            grant    <= pick;
            rr_ptr   <= pick;
            beat_cnt <= '0;
         end else if (load) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
      end
   end

   // Output stage: load on an accepted beat, hold under backpressure,
   // empty once downstream takes the beat and nothing new arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         src_q   <= '0;
      end else if (load) begin
         data_q  <= g_data;
         valid_q <= 1'b1;
         last_q  <= g_last || trunc;
         err_q   <= trunc;
         src_q   <= grant;
      end else if (bus.ready_i) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end
   end

   assign bus.req_ready_o = ready_vec;
   assign bus.data_o      = data_q;
   assign bus.valid_o     = valid_q;
   assign bus.last_o      = last_q;
   assign bus.err_o       = err_q;
   assign bus.src_o       = src_q;
   assign bus.busy_o      = (state != IDLE);

endmodule

// File: tb/tb_pipe_frame_arbiter.sv
// Self-checking bench for pipe_frame_arbiter. Requester frames are loaded
// into per-requester beat memories that a driver replays. Expected output
// beats go into a scoreboard queue, and a monitor collects the real ones.
module tb_pipe_frame_arbiter;
   localparam int N_REQ     = 4;
   localparam int DATA_W    = 8;
   localparam int MAX_BEATS = 8;
   localparam int SRC_W     = 2;
   localparam int DEPTH     = 64;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
      logic              err;
      logic [SRC_W-1:0]  src;
   } beat_t;

   typedef struct {
      beat_t b;
      int    gap;
   } exp_t;

   typedef struct {
      beat_t b;
      int    cyc;
   } obs_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   exp_t        expq[$];
   obs_t        obsq[$];
   obs_t        mon_obs;
   logic [8:0]  mem[N_REQ][DEPTH];
   int          wr_ptr[N_REQ];
   int          rd_ptr[N_REQ];
   bit [N_REQ-1:0] acc;
   bit          flush = 1'b0;
   int          cyc = 0;
   int          busy_cycles = 0;
   int          checks = 0;
   int          errors = 0;

   pipe_frame_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

   pipe_frame_arbiter #(
      .N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   // Requester driver: present the head of each beat memory, retire beats
   // accepted at the previous edge; idle requesters show random data/last.
   initial begin
      forever begin
         for (int k = 0; k < N_REQ; k++) begin
            if (rd_ptr[k] < wr_ptr[k]) begin
               {bus.req_last_i[k], bus.req_data_i[k*DATA_W +: DATA_W]} = mem[k][rd_ptr[k] % DEPTH];
               bus.req_valid_i[k] = 1'b1;
            end else begin
               bus.req_valid_i[k] = 1'b0;
               bus.req_last_i[k]  = 1'($urandom);
               bus.req_data_i[k*DATA_W +: DATA_W] = 8'($urandom);
            end
         end
         @(posedge clk);
         #1;
         for (int k = 0; k < N_REQ; k++) begin
            if (flush) rd_ptr[k] = wr_ptr[k];
            else if (acc[k]) rd_ptr[k] = rd_ptr[k] + 1;
         end
      end
   end

   // Monitor: sample away from the active edge, record handshakes and busy.
   always @(negedge clk) begin
      cyc = cyc + 1;
      acc = bus.req_valid_i & bus.req_ready_o;
      if (bus.busy_o) busy_cycles = busy_cycles + 1;
      if (bus.valid_o && bus.ready_i) begin
         mon_obs.b   = {bus.data_o, bus.last_o, bus.err_o, bus.src_o};
         mon_obs.cyc = cyc;
         obsq.push_back(mon_obs);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Queue a frame on requester k and push the beats the arbiter should emit.
   // gapmode 0: no timing check, 1: back-to-back beats, 2: also one bubble
   // before the first beat relative to the previous frame.
   task automatic applyStimulus(input int k, input int len, input logic [7:0] base, input int gapmode);
      exp_t e;
      int   n_out;
      for (int i = 0; i < len; i++) begin
         mem[k][wr_ptr[k] % DEPTH] = {(i == len - 1), 8'(base + 8'(i))};
         wr_ptr[k] = wr_ptr[k] + 1;
      end
      n_out = (len > MAX_BEATS) ? MAX_BEATS : len;
      for (int i = 0; i < n_out; i++) begin
         e.b.data = 8'(base + 8'(i));
         e.b.last = (i == len - 1) || (i == MAX_BEATS - 1);
         e.b.err  = (len > MAX_BEATS) && (i == MAX_BEATS - 1);
         e.b.src  = SRC_W'(k);
         if (gapmode == 0)  e.gap = 0;
         else if (i > 0)    e.gap = 1;
         else               e.gap = (gapmode == 2) ? 2 : 0;
         expq.push_back(e);
      end
   endtask

   task automatic checkScoreboard(input string tag);
      exp_t e;
      obs_t o;
      int   prev = -1;
      int   n = 0;
      int   t;
      while (expq.size() > 0) begin
         t = 0;
         while (obsq.size() == 0 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
         end
         if (obsq.size() == 0) begin
            checkOutput($sformatf("%s_timeout", tag), 32'(obsq.size()), 32'd1);
            expq.delete();
            return;
         end
         e = expq.pop_front();
         o = obsq.pop_front();
         checkOutput($sformatf("%s_beat%0d", tag, n), 32'(o.b), 32'(e.b));
         if (e.gap != 0 && prev >= 0)
            checkOutput($sformatf("%s_gap%0d", tag, n), 32'(o.cyc - prev), 32'(e.gap));
         prev = o.cyc;
         n++;
      end
      repeat (3) @(negedge clk);
      #1;
      checkOutput($sformatf("%s_extra", tag), 32'(obsq.size()), 32'd0);
   endtask

   task automatic waitIdle(input string tag);
      int t = 0;
      while (bus.busy_o && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      checkOutput(tag, 32'(bus.busy_o), 32'd0);
   endtask

   // Directed sequence covering reset, arbitration order, backpressure,
   // truncation, exact-length frames and reset in the middle of a frame.
   initial begin
      int   b0;
      int   t;
      obs_t junk;
      bus.ready_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      $display("[TB] reset values");
      checkOutput("rst_valid", 32'(bus.valid_o), 32'd0);
      checkOutput("rst_last",  32'(bus.last_o),  32'd0);
      checkOutput("rst_err",   32'(bus.err_o),   32'd0);
      checkOutput("rst_busy",  32'(bus.busy_o),  32'd0);
      checkOutput("rst_data",  32'(bus.data_o),  32'd0);
      checkOutput("rst_src",   32'(bus.src_o),   32'd0);
      checkOutput("rst_ready", 32'(bus.req_ready_o), 32'd0);
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      bus.ready_i = 1'b1;

      $display("[TB] round-robin");
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < N_REQ; k++)
            applyStimulus(k, 2, 8'(8'h40 + 8'(k*16) + 8'(r*4)), (r == 0 && k == 0) ? 1 : 2);
      checkScoreboard("rr");

      $display("[TB] single frame");
      b0 = busy_cycles;
      applyStimulus(2, 4, 8'hA0, 1);
      checkScoreboard("single");
      waitIdle("single_idle");
      checkOutput("single_busy", 32'(busy_cycles - b0), 32'd4);

      $display("[TB] backpressure");
      applyStimulus(1, 6, 8'hB0, 0);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(bus.valid_o && bus.data_o == 8'hB1) && t < 100);
      checkOutput("bp_reach", 32'(t < 100), 32'd1);
      @(posedge clk);
      #1;
      bus.ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput($sformatf("bp_data%0d", i),  32'(bus.data_o),      32'hB2);
         checkOutput($sformatf("bp_valid%0d", i), 32'(bus.valid_o),     32'd1);
         checkOutput($sformatf("bp_ready%0d", i), 32'(bus.req_ready_o), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.ready_i = 1'b1;
      checkScoreboard("bp");
      waitIdle("bp_idle");

      $display("[TB] truncation");
      b0 = busy_cycles;
      applyStimulus(1, 12, 8'hC0, 1);
      checkScoreboard("trunc");
      waitIdle("trunc_idle");
      checkOutput("trunc_busy",    32'(busy_cycles - b0), 32'd12);
      checkOutput("trunc_drained", 32'(wr_ptr[1] - rd_ptr[1]), 32'd0);
      checkOutput("trunc_noout",   32'(obsq.size()), 32'd0);
      applyStimulus(3, 2, 8'hD0, 1);
      checkScoreboard("after_trunc");
      waitIdle("after_trunc_idle");

      $display("[TB] exact length");
      b0 = busy_cycles;
      applyStimulus(0, 8, 8'hE0, 1);
      checkScoreboard("exact");
      waitIdle("exact_idle");
      checkOutput("exact_busy", 32'(busy_cycles - b0), 32'd8);

      $display("[TB] reset mid-frame");
      applyStimulus(0, 6, 8'h60, 1);
      expq.delete();
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(bus.valid_o && bus.data_o == 8'h62) && t < 100);
      checkOutput("mid_reach", 32'(t < 100), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_valid", 32'(bus.valid_o), 32'd0);
      checkOutput("mid_last",  32'(bus.last_o),  32'd0);
      checkOutput("mid_err",   32'(bus.err_o),   32'd0);
      checkOutput("mid_busy",  32'(bus.busy_o),  32'd0);
      checkOutput("mid_data",  32'(bus.data_o),  32'd0);
      checkOutput("mid_src",   32'(bus.src_o),   32'd0);
      checkOutput("mid_ready", 32'(bus.req_ready_o), 32'd0);
      flush = 1'b1;
      @(posedge clk);
      #2;
      flush = 1'b0;
      while (obsq.size() > 0) junk = obsq.pop_front();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("mid_no_replay", 32'(obsq.size()), 32'd0);
      applyStimulus(0, 3, 8'h80, 1);
      applyStimulus(1, 3, 8'h70, 2);
      checkScoreboard("post_rst");
      waitIdle("post_rst_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
